// File: rtl/ksa_pkg.sv
// Shared types and stage-count helper for the pipelined Kogge-Stone adder.
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Stage 0 (bitwise g/p), one stage per prefix level, one result stage.
    function automatic int num_stages(input int log2w);
        return log2w + 2;
    endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone prefix combine of a (G,P) pair with its lower-order neighbour.
module ksa_prefix_cell
    import ksa_pkg::*;
(
    input  gp_t cur,
    input  gp_t prev,
    output gp_t res
);

    assign res.g = cur.g | (cur.p & prev.g);
    assign res.p = cur.p & prev.p;

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with per-stage valid bits and
// backpressure that collapses bubbles.
module ksa_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NS = num_stages(LOG2W);

    logic [NS-1:0] vld;
    logic [NS-1:0] ld;
    logic [NS-1:0] adv;
    logic [NS-1:0] up_vld;

    // Walk from the output back: a stage may load if empty or if it advances.
    always_comb begin
        logic nxt_ld;
        adv    = '0;
        ld     = '0;
        nxt_ld = out_ready;
        for (int s = NS - 1; s >= 0; s--) begin
            adv[s] = vld[s] & nxt_ld;
            ld[s]  = ~vld[s] | adv[s];
            nxt_ld = ld[s];
        end
    end

    assign up_vld    = {vld[NS-2:0], in_valid};
    assign in_ready  = ld[0];
    assign out_valid = vld[NS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (ld[s]) vld[s] <= up_vld[s];
            end
        end
    end

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] p0;
    logic             cin_eff;
    gp_t  [WIDTH-1:0] tree0;

    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub | in_cin;
    assign g0      = in_a & b_eff;
    assign p0      = in_a ^ b_eff;

    // Element 0 is the carry-in as a bit -1 generate; element j holds bit j-1,
    // so after the tree element j is the carry into bit j.
    always_comb begin
        tree0    = '0;
        tree0[0] = '{g: cin_eff, p: 1'b0};
        for (int j = 1; j < WIDTH; j++) begin
            tree0[j] = '{g: g0[j-1], p: p0[j-1]};
        end
    end

    gp_t  [WIDTH-1:0] tree_q  [0:LOG2W];
    logic [WIDTH-1:0] hp_q    [0:LOG2W];
    logic             gm_q    [0:LOG2W];
    gp_t  [WIDTH-1:0] lvl_nxt [1:LOG2W];

    for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
        localparam int SPAN = 1 << k;
        gp_t [WIDTH-1:0] nxt;
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            if (j >= SPAN) begin : g_cell
                ksa_prefix_cell u_cell (
                    .cur  (tree_q[k][j]),
                    .prev (tree_q[k][j-SPAN]),
                    .res  (nxt[j])
                );
            end else begin : g_pass
                assign nxt[j] = tree_q[k][j];
            end
        end
        assign lvl_nxt[k+1] = nxt;
    end

    always_ff @(posedge clk) begin
        if (ld[0] && in_valid) begin
            tree_q[0] <= tree0;
            hp_q[0]   <= p0;
            gm_q[0]   <= g0[WIDTH-1];
        end
        for (int s = 1; s <= LOG2W; s++) begin
            if (ld[s] && vld[s-1]) begin
                tree_q[s] <= lvl_nxt[s];
                hp_q[s]   <= hp_q[s-1];
                gm_q[s]   <= gm_q[s-1];
            end
        end
    end

    logic [WIDTH-1:0] carry;
    logic             cout_d;
    logic             unused_p;

    always_comb begin
        carry    = '0;
        unused_p = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            carry[j] = tree_q[LOG2W][j].g;
            unused_p = unused_p ^ tree_q[LOG2W][j].p;
        end
    end

    assign cout_d = gm_q[LOG2W] | (hp_q[LOG2W][WIDTH-1] & carry[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (ld[NS-1] && vld[NS-2]) begin
            out_sum  <= hp_q[LOG2W] ^ carry;
            out_cout <= cout_d;
            out_ovf  <= carry[WIDTH-1] ^ cout_d;
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// Scoreboard bench for ksa_pipe at WIDTH=16: driver pushes expected results,
// monitor checks every presented output against the queue head.
module tb_ksa_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    ksa_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int hs_first = -1;
    int hs_last  = -1;
    logic [17:0] exp_q [$];

    always @(posedge clk) cyc++;

    // Result packed as {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return {full[16], ovf, full[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare any presented output with the queue head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output",
                             {out_cout, out_ovf, out_sum});
                end else begin
                    if ({out_cout, out_ovf, out_sum} !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL result: got cout/ovf/sum 0x%0h, expected 0x%0h",
                                 {out_cout, out_ovf, out_sum}, exp_q[0]);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                        if (hs_first < 0) hs_first = cyc;
                        hs_last = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [17:0] exp, output int acc_cyc);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        #2;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        acc_cyc = cyc;
        n_cmp++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0, expected 1");
        end else begin
            exp_q.push_back(exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic latency(input string name, input int acc_cyc);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            #2;
            t++;
        end
        check(name, cyc - acc_cyc, 6);
    endtask

    int acc;
    int acc_first;
    int n_acc;
    int ov_seen;
    logic [15:0] ra, rb;
    logic        rc, rs;

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_sub = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {out_cout, out_ovf, out_sum}, 0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_no_accept", out_valid, 0);
        rst_n = 1'b1;

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, acc);
        idle();
        latency("latency_first", acc);
        wait_drain();

        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, acc);
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h8000}, acc);
        send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, acc);
        send(16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF}, acc);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, acc);
        send(16'h5555, 16'h5555, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000}, acc);
        send(16'h0005, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0002}, acc);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, acc);
        idle();
        wait_drain();

        // 100-beat back-to-back stream.
        hs_cnt = 0; hs_first = -1; hs_last = -1; acc_first = -1;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), acc);
            if (acc_first < 0) acc_first = acc;
        end
        idle();
        check("stream_accept_span", acc - acc_first, 99);
        wait_drain();
        check("stream_count", hs_cnt, 100);
        check("stream_out_span", hs_last - hs_first, 99);

        // Output stall: pipeline fills to exactly six beats.
        hs_cnt = 0; n_acc = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            in_valid = 1'b1; in_a = ra; in_b = rb; in_cin = rc; in_sub = rs;
            #2;
            if (in_ready) begin
                exp_q.push_back(model(ra, rb, rc, rs));
                n_acc++;
            end
        end
        check("stall_accepted", n_acc, 6);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        ra = 16'hA5A5; rb = 16'h5A5A; rc = 1'b1; rs = 1'b0;
        in_valid = 1'b1; in_a = ra; in_b = rb; in_cin = rc; in_sub = rs;
        #2;
        check("full_simul_ready", in_ready, 1);
        if (in_ready) exp_q.push_back({1'b1, 1'b0, 16'h0000});
        idle();
        wait_drain();
        check("stall_drain_count", hs_cnt, 7);

        // Reset with three beats in flight.
        send(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002}, acc);
        send(16'h0002, 16'h0002, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0004}, acc);
        send(16'h0003, 16'h0003, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0006}, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        repeat (10) begin
            @(negedge clk);
            #2;
            if (out_valid) ov_seen++;
        end
        check("midrst_no_ghost", ov_seen, 0);
        send(16'h1111, 16'h2222, 1'b1, 1'b0, {1'b0, 1'b0, 16'h3334}, acc);
        idle();
        latency("latency_after_rst", acc);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
